// File: rtl/everloop_pkg.sv
// Shared definitions for the everloop LED ring datapath (fetch and serializer).
// Holds the fetch FSM state type, the gap-counter width and the helpers that
// turn board-level parameters into frame length and latch-gap length in cycles.
package everloop_pkg;

  // The latch-gap counter is 24 bits wide; long gaps at high clock rates fit.
  localparam int GAP_CNT_W = 24;

  typedef enum logic [2:0] {
    IDLE,   // line held low, waiting for enable
    GAP,    // inter-frame latch gap running
    ARM,    // waiting for the serializer to request the next byte
    READ,   // RAM access cycle
    LATCH,  // RAM data captured into the output byte
    DRAIN   // last byte handed over, waiting for it to finish shifting
  } state_t;

  // Number of bytes in one frame.
  function automatic int frame_bytes(input int led_count, input int bytes_per_led);
    return led_count * bytes_per_led;
  endfunction

  // Latch gap in clock cycles: ceil(sys_freq_hz * reset_us / 1e6).
  function automatic logic [GAP_CNT_W-1:0] reset_counter(input longint sys_freq_hz,
                                                         input longint reset_us);
    longint cycles;
    cycles = (sys_freq_hz * reset_us + longint'(999_999)) / longint'(1_000_000);
    return GAP_CNT_W'(cycles);
  endfunction

endpackage

// File: rtl/everloop_gap_timer.sv
// Latch-gap timer for the everloop fetch FSM.
// Counts clock cycles while start is high and flags the last cycle of the gap.
// Ports:
//   clk   - system clock
//   rst   - synchronous, active-low reset
//   clear - forces the count back to zero (takes priority over start)
//   start - count one cycle
//   tc    - high while counting and the count equals TERMINAL
module everloop_gap_timer
  import everloop_pkg::*;
#(
  parameter logic [GAP_CNT_W-1:0] TERMINAL = GAP_CNT_W'(99)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic start,
  output logic tc
);

  logic [GAP_CNT_W-1:0] count;

  // NOTE: sequential state uses <= so every flop samples pre-edge values and
  // the order of statements inside the block cannot change the result.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      count <= '0;
    end else if (start) begin
      count <= count + 1'b1;
    end
  end

  assign tc = start && (count == TERMINAL);

endmodule

// File: rtl/everloop_fetch.sv
// Byte sequencer feeding the everloop serializer.
// Reads frame bytes (G,R,B,W per LED) from a synchronous LED-image RAM and
// hands one byte to the serializer per en_rd request, then holds the LED line
// low for the latch gap before starting the next frame.
// Constraint: LED_COUNT*BYTES_PER_LED must not exceed 2**ADDR_WIDTH.
// Ports:
//   clk            - system clock
//   rst            - synchronous, active-low reset
//   enable         - refresh continuously; looked at only at frame boundaries
//   en_rd          - serializer request: previous byte fully shifted out
//   ack            - one-cycle strobe: data_RGB is valid
//   data_RGB       - byte to serialize
//   reset_everloop - force LED line low (latch gap / idle)
//   ram_rd         - RAM read enable
//   ram_addr       - RAM read address (holds while ram_rd is low)
//   ram_data       - RAM read data, valid the cycle after ram_rd
//   frame_done     - one-cycle pulse once the last byte has shifted out
module everloop_fetch
  import everloop_pkg::*;
#(
  parameter int SYS_FREQ_HZ   = 100_000_000,  // set to the real board clock
  parameter int LED_COUNT     = 35,
  parameter int BYTES_PER_LED = 4,
  parameter int ADDR_WIDTH    = 8,
  parameter int RESET_US      = 80
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  en_rd,
  output logic                  ack,
  output logic [7:0]            data_RGB,
  output logic                  reset_everloop,
  output logic                  ram_rd,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [7:0]            ram_data,
  output logic                  frame_done
);

  localparam int FRAME_BYTES = frame_bytes(LED_COUNT, BYTES_PER_LED);
  localparam logic [GAP_CNT_W-1:0] RESET_COUNTER =
    reset_counter(longint'(SYS_FREQ_HZ), longint'(RESET_US));
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME_BYTES - 1);

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   idx, idx_n;
  logic                    ack_n, frame_done_n, ram_rd_n, reset_everloop_n;
  logic [7:0]              data_n;
  logic [ADDR_WIDTH-1:0]   ram_addr_n;
  logic                    gap_tc;

  // Counter is held at zero outside GAP, so every gap starts from a clean count.
  everloop_gap_timer #(
    .TERMINAL (RESET_COUNTER - GAP_CNT_W'(1))
  ) u_gap_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (state != GAP),
    .start (state == GAP),
    .tc    (gap_tc)
  );

  // NOTE: every variable gets its default before the case statement, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n          = state;
    idx_n            = idx;
    ack_n            = 1'b0;
    frame_done_n     = 1'b0;
    ram_rd_n         = 1'b0;
    ram_addr_n       = ram_addr;
    data_n           = data_RGB;
    reset_everloop_n = reset_everloop;

    case (state)
      IDLE: begin
        reset_everloop_n = 1'b1;
        if (enable) state_n = GAP;
      end
      GAP: begin
        reset_everloop_n = 1'b1;
        if (gap_tc) state_n = ARM;
      end
      ARM: begin
        if (en_rd) begin
          ram_rd_n   = 1'b1;
          ram_addr_n = idx;
          state_n    = READ;
        end
      end
      READ: begin
        state_n = LATCH;
      end
      LATCH: begin
        // The line is released with the first byte of the frame, so the
        // first bit starts cleanly on an en_rd boundary.
        data_n           = ram_data;
        ack_n            = 1'b1;
        reset_everloop_n = 1'b0;
        if (idx == LAST_IDX) begin
          idx_n   = '0;
          state_n = DRAIN;
        end else begin
          idx_n   = idx + 1'b1;
          state_n = ARM;
        end
      end
      DRAIN: begin
        // en_rd here means the last byte has left the serializer.
        if (en_rd) begin
          frame_done_n     = 1'b1;
          reset_everloop_n = 1'b1;
          state_n          = enable ? GAP : IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      idx            <= '0;
      ack            <= 1'b0;
      data_RGB       <= '0;
      reset_everloop <= 1'b1;
      ram_rd         <= 1'b0;
      ram_addr       <= '0;
      frame_done     <= 1'b0;
    end else begin
      state          <= state_n;
      idx            <= idx_n;
      ack            <= ack_n;
      data_RGB       <= data_n;
      reset_everloop <= reset_everloop_n;
      ram_rd         <= ram_rd_n;
      ram_addr       <= ram_addr_n;
      frame_done     <= frame_done_n;
    end
  end

endmodule

// File: tb/tb_everloop_fetch.sv
// Self-checking bench for everloop_fetch.
// A cycle-level reference model decides, for each en_rd request, whether the
// block accepts it and schedules the expected ram_rd, ack, frame_done and
// line-level events into queues; a monitor compares them every cycle.
module tb_everloop_fetch;

  localparam int LED_COUNT   = 2;
  localparam int BPL         = 4;
  localparam int FRAME       = LED_COUNT * BPL;
  localparam int RC          = 100;  // 100 MHz * 1 us

  logic       clk = 1'b0;
  logic       rst, enable, en_rd;
  logic       ack, reset_everloop, ram_rd, frame_done;
  logic [7:0] data_RGB, ram_addr;
  logic [7:0] ram_data = 8'h00;
  logic [7:0] mem [256];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mon_on  = 1'b0;

  everloop_fetch #(
    .SYS_FREQ_HZ   (100_000_000),
    .LED_COUNT     (LED_COUNT),
    .BYTES_PER_LED (BPL),
    .ADDR_WIDTH    (8),
    .RESET_US      (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .en_rd          (en_rd),
    .ack            (ack),
    .data_RGB       (data_RGB),
    .reset_everloop (reset_everloop),
    .ram_rd         (ram_rd),
    .ram_addr       (ram_addr),
    .ram_data       (ram_data),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous LED-image RAM: data valid the cycle after the read strobe.
  always @(posedge clk) if (ram_rd) ram_data <= mem[ram_addr];

  typedef struct { int cyc; logic [7:0] data; int addr; } ev_t;
  typedef struct { int cyc; logic val; } lvl_t;
  ev_t  ack_q[$], rd_q[$], done_q[$];
  lvl_t rev_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum { M_IDLE, M_BYTES, M_DRAIN } mphase_t;
  mphase_t m_phase = M_IDLE;
  int      m_pos   = 0;
  int      m_ready = 0;  // first cycle at which a request is accepted

  // en_rd is high during cycle t.
  task automatic model_en_rd(input int t);
    if (m_phase == M_IDLE || t < m_ready) return;
    if (m_phase == M_BYTES) begin
      rd_q.push_back('{t + 1, 8'h00, m_pos});
      ack_q.push_back('{t + 3, mem[m_pos], m_pos});
      if (m_pos == 0) rev_q.push_back('{t + 3, 1'b0});
      m_pos++;
      m_ready = t + 3;
      if (m_pos == FRAME) m_phase = M_DRAIN;
    end else begin
      done_q.push_back('{t + 1, 8'h00, 0});
      rev_q.push_back('{t + 1, 1'b1});
      m_pos = 0;
      if (enable) begin
        m_phase = M_BYTES;
        m_ready = t + 1 + RC;
      end else begin
        m_phase = M_IDLE;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit er);
    @(negedge clk);
    en_rd = er;
    if (er) model_en_rd(cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0);
  endtask

  task automatic pulse_after(input int n);
    idle(n - 1);
    step(1'b1);
  endtask

  task automatic set_enable(input bit v);
    @(negedge clk);
    en_rd  = 1'b0;
    enable = v;
    if (v && m_phase == M_IDLE) begin
      m_phase = M_BYTES;
      m_pos   = 0;
      m_ready = cyc + 1 + RC;
    end
  endtask

  task automatic do_reset();
    int k;
    @(negedge clk);
    rst   = 1'b0;
    en_rd = 1'b0;
    k     = cyc;
    while (ack_q.size()  > 0 && ack_q[$].cyc  > k) void'(ack_q.pop_back());
    while (rd_q.size()   > 0 && rd_q[$].cyc   > k) void'(rd_q.pop_back());
    while (done_q.size() > 0 && done_q[$].cyc > k) void'(done_q.pop_back());
    while (rev_q.size()  > 0 && rev_q[$].cyc  > k) void'(rev_q.pop_back());
    rev_q.push_back('{k + 1, 1'b1});
    m_phase = M_IDLE;
    m_pos   = 0;
    repeat (3) begin
      @(negedge clk);
      check("rst_ack", ack, 1'b0);
      check("rst_data_RGB", data_RGB, 8'h00);
      check("rst_reset_everloop", reset_everloop, 1'b1);
      check("rst_ram_rd", ram_rd, 1'b0);
      check("rst_ram_addr", ram_addr, 8'h00);
      check("rst_frame_done", frame_done, 1'b0);
    end
    rst    = 1'b1;
    mon_on = 1'b1;
    if (enable) begin
      m_phase = M_BYTES;
      m_ready = cyc + 1 + RC;
    end
  endtask

  // ---------------- monitor ----------------
  logic exp_rev = 1'b1;
  always @(negedge clk) begin
    logic e, chg;
    if (mon_on) begin
      e = ack_q.size() > 0 && ack_q[0].cyc == cyc;
      if (e || ack !== 1'b0) begin
        check("ack", ack, e);
        if (e) begin
          check("data_RGB", data_RGB, ack_q[0].data);
          check("ram_addr_hold", ram_addr, ack_q[0].addr);
          void'(ack_q.pop_front());
        end
      end
      e = rd_q.size() > 0 && rd_q[0].cyc == cyc;
      if (e || ram_rd !== 1'b0) begin
        check("ram_rd", ram_rd, e);
        if (e) begin
          check("ram_addr", ram_addr, rd_q[0].addr);
          void'(rd_q.pop_front());
        end
      end
      e = done_q.size() > 0 && done_q[0].cyc == cyc;
      if (e || frame_done !== 1'b0) begin
        check("frame_done", frame_done, e);
        if (e) void'(done_q.pop_front());
      end
      chg = 1'b0;
      while (rev_q.size() > 0 && rev_q[0].cyc <= cyc) begin
        exp_rev = rev_q[0].val;
        chg     = 1'b1;
        void'(rev_q.pop_front());
      end
      if (chg || reset_everloop !== exp_rev) check("reset_everloop", reset_everloop, exp_rev);
    end
  end

  // ---------------- scenario ----------------
  initial begin
    rst    = 1'b0;
    enable = 1'b1;
    en_rd  = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < FRAME; i++) mem[i] = 8'(8'h11 * (i + 1));

    do_reset();                        // reset values, gap before first byte
    repeat (FRAME) pulse_after(200);   // one full frame, slow requests
    pulse_after(200);                  // drain: frame_done, new gap

    pulse_after(50);                   // request inside the gap: ignored
    pulse_after(60);                   // first request after the gap: byte 0
    step(1'b1); step(1'b1); step(1'b1);  // READ, LATCH ignored; ARM accepted
    repeat (FRAME - 1) pulse_after(5); // rest of frame plus drain

    idle(110);
    repeat (3) pulse_after(20);
    idle(3);
    set_enable(1'b0);                  // frame must still complete
    repeat (FRAME - 3 + 1) pulse_after(20);
    repeat (4) pulse_after(30);        // idle: no reads

    set_enable(1'b1);
    idle(110);
    repeat (5) pulse_after(10);        // byte 4 accepted
    step(1'b0);
    do_reset();                        // lands on the LATCH cycle of byte 4
    idle(110);
    repeat (FRAME + 1) pulse_after(10);

    for (int i = 0; i < FRAME; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 299);
      if (r == 0)      do_reset();
      else if (r < 4)  set_enable(!enable);
      else             step(r < 60);
    end

    idle(300);
    check("queues_drained", ack_q.size() + rd_q.size() + done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
